// File: rtl/signed_div_adapter.sv
// rtl/signed_div_adapter.sv - signed/unsigned front end for a 64-bit unsigned iterative divider
// Special cases (x/0, MIN/-1) can be answered locally; all others go through the divider with sign fix-up.
module signed_div_adapter #(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_quotient,
  output logic [63:0] resp_remainder,
  output logic        div_start,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  input  logic        div_valid,
  input  logic [63:0] div_quotient,
  input  logic [63:0] div_remainder
);

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [63:0] r_mag_a;
  logic [63:0] r_mag_b;
  logic [63:0] r_quot;
  logic [63:0] r_rem;

  logic        w_sign_a;
  logic        w_sign_b;
  logic        w_div_zero;
  logic        w_overflow;
  logic        w_bypass;
  logic        w_accept;
  logic        w_capture;

  always_comb begin
    w_sign_a   = req_signed & req_a[63];
    w_sign_b   = req_signed & req_b[63];
    w_div_zero = (req_b == 64'd0);
    w_overflow = req_signed && (req_a == MIN_NEG) && (req_b == '1);
    w_bypass   = BYPASS_SPECIAL && (w_div_zero || w_overflow);
    w_accept   = (r_state == IDLE) && req_valid;
    w_capture  = (r_state == ISSUE) && div_valid;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    div_start  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_bypass ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        if (div_valid) begin
          w_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Magnitudes are held from acceptance until the next request, so div_a/div_b stay stable through ISSUE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= 64'd0;
      r_mag_b  <= 64'd0;
      r_quot   <= 64'd0;
      r_rem    <= 64'd0;
    end else if (w_accept) begin
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_mag_a  <= w_sign_a ? -req_a : req_a;
      r_mag_b  <= w_sign_b ? -req_b : req_b;
      if (w_div_zero) begin
        r_quot <= '1;
        r_rem  <= req_a;
      end else if (w_overflow) begin
        r_quot <= MIN_NEG;
        r_rem  <= 64'd0;
      end
    end else if (w_capture) begin
      r_quot <= (r_sign_a ^ r_sign_b) ? -div_quotient : div_quotient;
      r_rem  <= r_sign_a ? -div_remainder : div_remainder;
    end
  end

  assign div_a          = r_mag_a;
  assign div_b          = r_mag_b;
  assign resp_quotient  = r_quot;
  assign resp_remainder = r_rem;

endmodule

// File: tb/tb_signed_div_adapter.sv
// tb/tb_signed_div_adapter.sv - directed self-checking bench for signed_div_adapter
// The bench plays the divider; expected results come from plain signed/unsigned arithmetic.
module tb_signed_div_adapter;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_quotient;
  logic [63:0] resp_remainder;
  logic        div_start;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic        div_valid;
  logic [63:0] div_quotient;
  logic [63:0] div_remainder;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  int          phase    = 0;   // 0 idle, 1 divider busy, 2 response pending
  int          low_run  = 100;
  logic [63:0] exp_q, exp_r, exp_da, exp_db;

  signed_div_adapter #(.BYPASS_SPECIAL(1'b1)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_signed     (req_signed),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .div_start      (div_start),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_valid      (div_valid),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                                output logic [63:0] q, output logic [63:0] r,
                                output logic [63:0] da, output logic [63:0] db, output bit special);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    da = (sgn && sa < 0) ? 64'd0 - a : a;
    db = (sgn && sb < 0) ? 64'd0 - b : b;
    special = 1'b1;
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (sgn && a == MIN_NEG && b == ONES) begin
      q = MIN_NEG;
      r = 64'd0;
    end else begin
      special = 1'b0;
      if (sgn) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("req_ready", {63'd0, req_ready}, {63'd0, phase == 0});
      chk("div_start", {63'd0, div_start}, {63'd0, phase == 1});
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, phase == 2});
      if (phase == 1) begin
        chk("div_a", div_a, exp_da);
        chk("div_b", div_b, exp_db);
      end
      if (phase == 2) begin
        chk("resp_quotient", resp_quotient, exp_q);
        chk("resp_remainder", resp_remainder, exp_r);
      end
      if (div_start) begin
        if (low_run > 0) chk("div_start_gap", {63'd0, low_run >= 2}, 64'd1);
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                        input int k, input int hold,
                        input logic [63:0] pin_q, input logic [63:0] pin_r, input bit pin_issue);
    logic [63:0] mq, mr, mda, mdb;
    bit          msp;
    model(a, b, sgn, mq, mr, mda, mdb, msp);
    chk("model_q", mq, pin_q);
    chk("model_r", mr, pin_r);
    chk("model_issue", {63'd0, !msp}, {63'd0, pin_issue});
    exp_q  = mq;
    exp_r  = mr;
    exp_da = mda;
    exp_db = mdb;
    @(negedge clock);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_signed = sgn;
    @(posedge clock);
    #1;
    // keep offering junk: it must be ignored until the adapter is idle again
    req_a      = {$urandom, $urandom};
    req_b      = {$urandom, $urandom};
    req_signed = ~sgn;
    if (!msp) begin
      phase = 1;
      for (int i = 1; i <= k; i++) begin
        @(negedge clock);
        if (i == k) begin
          div_valid     = 1'b1;
          div_quotient  = mda / mdb;
          div_remainder = mda % mdb;
        end
      end
      @(posedge clock);
      #1;
      div_valid     = 1'b0;
      div_quotient  = {$urandom, $urandom};
      div_remainder = {$urandom, $urandom};
    end
    phase = 2;
    for (int i = 0; i < hold; i++) @(negedge clock);
    @(negedge clock);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    phase      = 0;
  endtask

  initial begin
    resetn        = 1'b0;
    req_valid     = 1'b0;
    req_a         = 64'd0;
    req_b         = 64'd0;
    req_signed    = 1'b0;
    resp_ready    = 1'b0;
    div_valid     = 1'b0;
    div_quotient  = 64'd0;
    div_remainder = 64'd0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_div_a", div_a, 64'd0);
    chk("reset_resp_q", resp_quotient, 64'd0);

    run_op(-64'sd7, 64'd2, 1'b1, 3, 0, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b1);
    run_op(64'd100, 64'd7, 1'b0, 20, 0, 64'd14, 64'd2, 1'b1);
    run_op(64'd5, 64'd0, 1'b1, 1, 0, ONES, 64'd5, 1'b0);
    run_op(MIN_NEG, ONES, 1'b1, 1, 0, MIN_NEG, 64'd0, 1'b0);
    run_op(64'd7, -64'sd2, 1'b1, 2, 3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b1);
    run_op(-64'sd100, -64'sd7, 1'b1, 1, 0, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    run_op(ONES, 64'd1, 1'b0, 1, 0, ONES, 64'd0, 1'b1);
    run_op(64'h1234, 64'd0, 1'b0, 1, 2, ONES, 64'h1234, 1'b0);
    run_op(MIN_NEG, ONES, 1'b0, 4, 0, 64'd0, MIN_NEG, 1'b1);

    // abandon an operation in flight, then ignore a stale divider strobe
    exp_da = 64'd9;
    exp_db = 64'd4;
    @(negedge clock);
    req_valid  = 1'b1;
    req_a      = -64'sd9;
    req_b      = 64'd4;
    req_signed = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    phase     = 1;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    phase  = 0;
    @(negedge clock);
    chk("abort_div_a", div_a, 64'd0);
    chk("abort_div_b", div_b, 64'd0);
    chk("abort_resp_q", resp_quotient, 64'd0);
    chk("abort_resp_r", resp_remainder, 64'd0);
    div_valid     = 1'b1;
    div_quotient  = 64'd2;
    div_remainder = 64'd1;
    @(posedge clock);
    #1;
    div_valid = 1'b0;
    repeat (2) @(negedge clock);
    run_op(-64'sd9, 64'd4, 1'b1, 2, 1, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 1'b1);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signed_div_adapter.md
SIGNED_DIV_ADAPTER -- requirements
Module: signed_div_adapter

Interface
REQ-001 Parameter BYPASS_SPECIAL, default 1: 1 resolves divide-by-zero and signed overflow locally without issuing the divider; 0 issues every operation to the divider.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  request operands valid.
REQ-005 req_ready  output  1  adapter accepts a request this cycle.
REQ-006 req_a  input  64  dividend.
REQ-007 req_b  input  64  divisor.
REQ-008 req_signed  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-009 resp_valid  output  1  result valid.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_quotient  output  64  final quotient.
REQ-012 resp_remainder  output  64  final remainder.
REQ-013 div_start  output  1  level start to the 64-bit unsigned divider.
REQ-014 div_a  output  64  unsigned dividend to the divider.
REQ-015 div_b  output  64  unsigned divisor to the divider.
REQ-016 div_valid  input  1  divider result strobe, one cycle.
REQ-017 div_quotient  input  64  divider quotient.
REQ-018 div_remainder  input  64  divider remainder.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and DONE; req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, req_valid=1 SHALL register the operands, req_signed, sign_a=req_signed&req_a[63] and sign_b=req_signed&req_b[63].
REQ-021 The registered magnitudes SHALL be the two's-complement negation of the operand when its sign flag is 1, else the operand unchanged; div_a/div_b SHALL drive these registers.
REQ-022 The request SHALL be special when req_b==0 (divide by zero) or when req_signed=1, req_a=0x8000_0000_0000_0000 and req_b=all ones (signed overflow).
REQ-023 With BYPASS_SPECIAL=1, a special request SHALL go IDLE->DONE, leave div_start at 0, and assert resp_valid on the next cycle (1-cycle latency).
REQ-024 Divide-by-zero SHALL return quotient=0xFFFF_FFFF_FFFF_FFFF and remainder=req_a in both signed and unsigned mode.
REQ-025 Signed overflow SHALL return quotient=0x8000_0000_0000_0000 and remainder=0.
REQ-026 A non-special request SHALL go IDLE->ISSUE, and div_start SHALL be 1 for every cycle in ISSUE.
REQ-027 div_a and div_b SHALL stay stable from the first div_start=1 cycle through the div_valid cycle.
REQ-028 In ISSUE, div_valid=1 SHALL register the results, deassert div_start on the next cycle, and move to DONE.
REQ-029 Sign fix-up SHALL negate the quotient when sign_a^sign_b=1 and negate the remainder when sign_a=1; unsigned results SHALL pass through unchanged.
REQ-030 Normal latency SHALL be: request accepted at cycle 0, div_start=1 from cycle 1, div_valid at cycle k, resp_valid=1 at cycle k+1.
REQ-031 In DONE, resp_valid SHALL be 1 and resp_quotient/resp_remainder SHALL hold stable until resp_ready=1; the transition to IDLE SHALL happen on that edge.
REQ-032 div_start SHALL be 0 for at least 2 consecutive cycles between successive divider operations; this is guaranteed by DONE plus IDLE each lasting at least one cycle.
REQ-033 div_valid SHALL be ignored in IDLE and DONE; req_valid SHALL be ignored outside IDLE.
REQ-034 With BYPASS_SPECIAL=0, special requests SHALL use the divider, and the divider result after fix-up SHALL be passed through unchanged.

Reset
REQ-035 resetn=0 at a rising edge SHALL force IDLE, div_start=0, resp_valid=0, req_ready=1 on the following cycle, and clear all data registers to 0, from any state.
REQ-036 A divider operation in flight at reset SHALL be abandoned, and no response SHALL be produced for it.

Verification
REQ-037 Signed a=-7, b=2 -> div_a=7, div_b=2; divider returns 3 and 1 -> resp_quotient=-3 (0xFFFF_FFFF_FFFF_FFFD), resp_remainder=-1.
REQ-038 Unsigned a=100, b=7, divider valid after 20 cycles -> quotient=14, remainder=2, resp_valid exactly 1 cycle after div_valid.
REQ-039 Signed a=5, b=0 with BYPASS_SPECIAL=1 -> div_start never 1, resp_valid at cycle 1, quotient=all ones, remainder=5.
REQ-040 Signed a=0x8000_0000_0000_0000, b=all ones -> quotient=0x8000_0000_0000_0000, remainder=0, no divider issue.
REQ-041 resp_ready held 0 for 3 cycles in DONE -> outputs stable and req_ready=0 throughout; back-to-back requests show div_start low for at least 2 cycles between operations.
REQ-042 resetn=0 in ISSUE, then div_valid pulses after reset -> div_start=0, resp_valid stays 0, and the next request completes correctly.
